// File: rtl/result_capture.sv
// Captures one frame of signed samples into a BRAM write port and keeps min/max/sum stats.
// Writes land one cycle after their sample_tick; the block never backpressures and DONE ignores ticks.
module result_capture #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 80,
    parameter int ADDR_W = 8,
    parameter int SKIP   = 4,
    parameter int SUM_W  = 16
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min,
    output logic [SUM_W-1:0]  sum
);

    localparam int                SKIP_W    = (SKIP < 2) ? 1 : $clog2(SKIP);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam int                EXT_W     = SUM_W - DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_start_d;
    logic                r_start_low_seen;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic                r_ena;
    logic [ADDR_W-1:0]   r_addra;
    logic [DATA_W-1:0]   r_dina;
    logic [ADDR_W-1:0]   r_count;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;
    logic [SUM_W-1:0]    r_sum;

    logic                w_start_edge;
    logic                w_arm;
    logic                w_settle_exit;
    logic                w_cap;
    logic                w_last;
    logic [SUM_W-1:0]    w_sample_ext;

    // A start level present at reset release must be seen low once before it can fire.
    assign w_start_edge  = start && !r_start_d && r_start_low_seen;
    assign w_arm         = w_start_edge && ((r_state == S_IDLE) || (r_state == S_DONE));
    // The tick that completes the settle count is itself discarded.
    assign w_settle_exit = (SKIP == 0) || (sample_tick && (r_skip_cnt == SKIP_LAST));
    assign w_cap         = (r_state == S_CAPTURE) && sample_tick;
    assign w_last        = w_cap && (r_count == LAST_ADDR);
    assign w_sample_ext  = {{EXT_W{sample_in[DATA_W-1]}}, sample_in};

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_edge)  w_next = S_SETTLE;
            S_SETTLE:  if (w_settle_exit) w_next = S_CAPTURE;
            S_CAPTURE: if (w_last)        w_next = S_DONE;
            S_DONE:    if (w_start_edge)  w_next = S_SETTLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_start_d        <= 1'b0;
            r_start_low_seen <= 1'b0;
        end else begin
            r_start_d <= start;
            if (!start) begin
                r_start_low_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= '0;
            r_ena      <= 1'b0;
            r_addra    <= '0;
            r_dina     <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_max      <= MOST_NEG;
            r_min      <= MOST_POS;
        end else begin
            r_ena <= w_cap;
            if (w_arm) begin
                r_skip_cnt <= '0;
                r_addra    <= '0;
                r_count    <= '0;
                r_sum      <= '0;
                r_max      <= MOST_NEG;
                r_min      <= MOST_POS;
            end
            if ((r_state == S_SETTLE) && sample_tick) begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
            end
            if (w_cap) begin
                r_addra <= r_count;
                r_dina  <= sample_in;
                r_count <= r_count + 1'b1;
                r_sum   <= r_sum + w_sample_ext;
                if ($signed(sample_in) > $signed(r_max)) begin
                    r_max <= sample_in;
                end
                if ($signed(sample_in) < $signed(r_min)) begin
                    r_min <= sample_in;
                end
            end
        end
    end

    assign ena      = r_ena;
    assign wea      = r_ena;
    assign addra    = r_addra;
    assign dina     = r_dina;
    assign count    = r_count;
    assign sum      = r_sum;
    assign peak_max = r_max;
    assign peak_min = r_min;
    assign busy     = (r_state == S_SETTLE) || (r_state == S_CAPTURE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_result_capture.sv
// Bench for result_capture: one instance with SKIP=4, one with SKIP=0, writes checked against a scoreboard.
module tb_result_capture;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       st_a, tk_a, st_b, tk_b;
    logic [8:0] smp_a, smp_b;
    logic       ena_a, wea_a, busy_a, done_a, ena_b, wea_b, busy_b, done_b;
    logic [7:0] addra_a, count_a, addra_b, count_b;
    logic [8:0] dina_a, pmax_a, pmin_a, dina_b, pmax_b, pmin_b;
    logic [15:0] sum_a, sum_b;

    result_capture #(.SKIP(4)) u_dut_a (
        .CLK100MHZ(clk), .reset(rst), .start(st_a), .sample_tick(tk_a), .sample_in(smp_a),
        .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a), .busy(busy_a), .done(done_a),
        .count(count_a), .peak_max(pmax_a), .peak_min(pmin_a), .sum(sum_a)
    );

    result_capture #(.SKIP(0)) u_dut_b (
        .CLK100MHZ(clk), .reset(rst), .start(st_b), .sample_tick(tk_b), .sample_in(smp_b),
        .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b), .busy(busy_b), .done(done_b),
        .count(count_b), .peak_max(pmax_b), .peak_min(pmin_b), .sum(sum_b)
    );

    int errors = 0;
    int checks = 0;
    logic [16:0] q_a[$];
    logic [16:0] q_b[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every write strobe must match the oldest expected (addr, data) entry.
    always @(negedge clk) begin
        logic [16:0] e;
        if (ena_a !== 1'b0 || wea_a !== 1'b0) begin
            check("a_ena", int'(ena_a), 1);
            check("a_wea", int'(wea_a), 1);
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_write: addra=%0d dina=%0d with nothing expected", addra_a, dina_a);
            end else begin
                e = q_a.pop_front();
                check("a_addra", int'(addra_a), int'(e[16:9]));
                check("a_dina", int'($signed(dina_a)), int'($signed(e[8:0])));
            end
        end
        if (ena_b !== 1'b0 || wea_b !== 1'b0) begin
            check("b_ena", int'(ena_b), 1);
            check("b_wea", int'(wea_b), 1);
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_write: addra=%0d dina=%0d with nothing expected", addra_b, dina_b);
            end else begin
                e = q_b.pop_front();
                check("b_addra", int'(addra_b), int'(e[16:9]));
                check("b_dina", int'($signed(dina_b)), int'($signed(e[8:0])));
            end
        end
    end

    initial begin
        logic [8:0] s;
        rst = 1'b1;
        st_a = 0; tk_a = 0; smp_a = '0;
        st_b = 0; tk_b = 0; smp_b = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Idle: ticks without a start produce nothing
        for (int i = 0; i < 10; i++) begin
            tk_a = 1; tk_b = 1; smp_a = 9'(i); smp_b = 9'(i);
            step();
        end
        tk_a = 0; tk_b = 0;
        step();
        check("idle_count", int'(count_a), 0);
        check("idle_busy", int'(busy_a), 0);
        check("idle_done", int'(done_a), 0);
        check("idle_pmax", int'($signed(pmax_a)), -256);
        check("idle_pmin", int'($signed(pmin_a)), 255);
        check("idle_sum", int'($signed(sum_a)), 0);
        check("idle_b_count", int'(count_b), 0);

        // Basic frame on SKIP=4: samples 0..83, first four discarded
        st_a = 1; step(); st_a = 0;
        check("a1_busy", int'(busy_a), 1);
        for (int i = 0; i < 84; i++) begin
            tk_a = 1; smp_a = 9'(i);
            if (i >= 4) q_a.push_back({8'(i - 4), 9'(i)});
            if (i == 83) check("a1_done_before", int'(done_a), 0);
            step();
        end
        tk_a = 0;
        check("a1_done_after", int'(done_a), 1);
        check("a1_busy_end", int'(busy_a), 0);
        check("a1_count", int'(count_a), 80);
        check("a1_sum", int'($signed(sum_a)), 3480);
        check("a1_pmin", int'($signed(pmin_a)), 4);
        check("a1_pmax", int'($signed(pmax_a)), 83);
        check("a1_addra_hold", int'(addra_a), 79);

        // Second frame with a mid-capture start pulse, then ticks after done
        st_a = 1; step(); st_a = 0;
        for (int i = 0; i < 84; i++) begin
            tk_a = 1; smp_a = 9'(i);
            st_a = (i == 40);
            if (i >= 4) q_a.push_back({8'(i - 4), 9'(i)});
            step();
        end
        st_a = 0;
        for (int i = 0; i < 5; i++) begin
            tk_a = 1; smp_a = 9'(200);
            step();
        end
        tk_a = 0;
        check("a2_count", int'(count_a), 80);
        check("a2_done", int'(done_a), 1);
        check("a2_sum", int'($signed(sum_a)), 3480);

        // SKIP=0 signed extremes, isolated ticks
        st_b = 1; step(); st_b = 0;
        check("b1_busy", int'(busy_b), 1);
        step();
        for (int i = 0; i < 80; i++) begin
            s = (i % 2 == 0) ? 9'h100 : 9'h0FF;
            tk_b = 1; smp_b = s;
            q_b.push_back({8'(i), s});
            if (i == 79) check("b1_done_before", int'(done_b), 0);
            step();
            tk_b = 0;
            if (i == 79) check("b1_done_after", int'(done_b), 1);
            step();
        end
        check("b1_pmin", int'($signed(pmin_b)), -256);
        check("b1_pmax", int'($signed(pmax_b)), 255);
        check("b1_sum", int'($signed(sum_b)), -40);
        check("b1_count", int'(count_b), 80);

        // SKIP=0 back-to-back ticks of -3
        st_b = 1; step(); st_b = 0;
        step();
        for (int i = 0; i < 80; i++) begin
            tk_b = 1; smp_b = 9'h1FD;
            q_b.push_back({8'(i), 9'h1FD});
            step();
        end
        tk_b = 0;
        check("b2_done", int'(done_b), 1);
        check("b2_count", int'(count_b), 80);
        check("b2_sum", int'($signed(sum_b)), -240);
        check("b2_pmax", int'($signed(pmax_b)), -3);
        check("b2_pmin", int'($signed(pmin_b)), -3);

        // Re-arm from DONE; first write must land at 0, then reset mid-frame
        st_a = 1; step(); st_a = 0;
        for (int i = 0; i < 4; i++) begin
            tk_a = 1; smp_a = 9'h1AA;
            step();
        end
        for (int i = 0; i < 38; i++) begin
            tk_a = 1; smp_a = 9'(i + 10);
            if (i == 20) st_a = 1;
            q_a.push_back({8'(i), 9'(i + 10)});
            step();
        end
        tk_a = 0;
        check("a3_count", int'(count_a), 38);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_ena", int'(ena_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_count", int'(count_a), 0);
        check("rst_addra", int'(addra_a), 0);
        check("rst_sum", int'($signed(sum_a)), 0);
        check("rst_pmax", int'($signed(pmax_a)), -256);
        check("rst_pmin", int'($signed(pmin_a)), 255);
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("held_start_no_arm", int'(busy_a), 0);
        st_a = 0; step();
        st_a = 1; step();
        check("toggled_start_arms", int'(busy_a), 1);
        st_a = 0;
        repeat (3) step();

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
